fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the main decoder. Holds the program counter and requests instructions from instruction memory over a req/ack handshake. Presents the held instruction to decode, whose `instr_o[31:26]` drives the decoder opcode input. Computes the next PC from the decoder's branch/jump outputs and the ALU zero flag, then advances when decode retires the instruction.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  32  instruction-memory byte address.
- imem_ack  input  1  memory has data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word.
- instr_o  output  32  held instruction; bits [31:26] feed the decoder OP.
- instr_valid  output  1  instr_o and pc_o are valid for decode/execute.
- pc_o  output  32  PC of the held instruction.
- pc_plus4_o  output  32  pc_o + 4; used for the JAL link value.
- decode_ready  input  1  execute completes the held instruction this cycle.
- branch_eq_i  input  1  decoder BranchEQ.
- branch_ne_i  input  1  decoder BranchNE.
- jump_i  input  1  decoder Jump.
- zero_i  input  1  ALU zero flag.
- jr_i  input  1  jump-register (from function-field decode).
- jr_target_i  input  32  rs value for JR.
- retired_cnt  output  CNT_WIDTH  count of retired instructions.

Behaviour:
- Reset (asynchronous, active-high):
  - pc_o=RESET_PC; instr_o=0; instr_valid=0; imem_req=0; retired_cnt=0; state=FETCH.
  - Reset asserted mid-handshake aborts the fetch. Any ack seen while reset is high is ignored.
- FSM states: FETCH, HOLD (plus HALT, only with the optional feature).
- FETCH:
  - imem_req=1 and imem_addr=pc_o, both held stable until imem_ack.
  - On imem_ack: instr_o<=imem_rdata, instr_valid<=1, next state HOLD.
  - ack arriving in the same cycle req rises is legal, giving zero wait states.
- HOLD:
  - imem_req=0; instr_o and pc_o are held stable.
  - imem_ack in HOLD is ignored.
  - When decode_ready=1: pc_o<=next_pc, instr_valid<=0, retired_cnt<=retired_cnt+1 (wraps modulo 2^CNT_WIDTH), next state FETCH.
  - decode_ready in FETCH is ignored.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then HOLD with decode_ready=1).
- next_pc, combinational from HOLD-state values; priority is highest first:
  1. jr_i: jr_target_i.
  2. jump_i: {pc_plus4_o[31:28], instr_o[25:0], 2'b00}.
  3. taken = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i): pc_plus4_o + ({{14{instr_o[15]}}, instr_o[15:0], 2'b00}).
  4. otherwise: pc_plus4_o.
- branch_eq_i and branch_ne_i both high: taken when either condition holds, with no error.
- Arithmetic: all additions are 32-bit, carry-out discarded. PC wraps from 32'hFFFF_FFFC to 0.
- Misaligned target (next_pc[1:0]!=0): bits [1:0] are forced to 2'b00 before loading pc_o.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Extra output `misalign_o` (1 bit, reset 0).
  - On retire with next_pc[1:0]!=0: pc_o loads the unmodified next_pc, misalign_o<=1 (sticky until reset), retired_cnt still increments, state=HALT.
  - HALT: imem_req=0, instr_valid=0, no further fetches; exit only by reset.
- Undefined: no misalign_o port, no HALT state; the low bits are silently forced to 00.

Test Plan:
- Reset release: first cycle after reset deasserts shows imem_req=1, imem_addr=32'h0040_0000, retired_cnt=0.
- Ack delayed 3 cycles: imem_addr stays stable throughout. imem_rdata=32'h2008_0005 gives instr_valid=1 and instr_o=32'h2008_0005. Hold decode_ready=0 for 4 cycles: outputs stable. Pulse decode_ready: next imem_addr=32'h0040_0004, retired_cnt=1.
- BEQ taken, pc_o=32'h0040_0008, instr_o=32'h1109_0003, branch_eq_i=1, zero_i=1, decode_ready=1 → next imem_addr=32'h0040_0018. Same with zero_i=0 → 32'h0040_000C.
- BNE with negative offset, pc_o=32'h0040_0010, imm=16'hFFFC, branch_ne_i=1, zero_i=0 → 32'h0040_0004.
- J instr_o=32'h0810_0004 plus jr_i=0 → 32'h0040_0010. Then jr_i=1, jump_i=1, jr_target_i=32'h0040_0020 → 32'h0040_0020 (JR wins).
- Reset asserted during FETCH wait and during HOLD → immediately pc_o=RESET_PC, instr_valid=0, imem_req=0; late ack ignored. With the macro defined, jr_target_i=32'h0040_0006 → misalign_o=1, HALT, no imem_req.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage that sits directly upstream of the main decoder.
//
// Holds the program counter and fetches one instruction at a time from instruction
// memory over a req/ack handshake. The held word goes to decode on instr_o; its bits
// [31:26] drive the decoder opcode. When decode retires the instruction, the unit
// computes the next PC from the decoder's branch/jump controls and the ALU zero flag,
// then starts the next fetch.
//
// Configuration macro:
//   FETCH_MISALIGN_TRAP_EN - When defined, a misaligned next PC traps. The unit adds
//                            the misalign_o output and a HALT state. When undefined,
//                            the low two bits of the next PC are forced to zero.
//
// Ports:
//   clk, reset           - Rising-edge clock and asynchronous active-high reset.
//   imem_req/imem_addr   - Fetch request and byte address (the address is pc_o).
//   imem_ack/imem_rdata  - Memory returns the instruction word while ack is high.
//   instr_o, instr_valid - Held instruction and its valid flag, driven to decode.
//   pc_o, pc_plus4_o     - PC of the held instruction, and that PC + 4 (JAL link).
//   decode_ready         - Execute completes the held instruction this cycle.
//   branch_eq_i, branch_ne_i, jump_i, zero_i, jr_i, jr_target_i
//                        - Next-PC controls from the decoder and the ALU.
//   retired_cnt          - Count of retired instructions; wraps around.
//   misalign_o           - Sticky misaligned-target trap flag (trap build only).

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          instr_o,
    output logic                 instr_valid,
    output logic [31:0]          pc_o,
    output logic [31:0]          pc_plus4_o,
    input  logic                 decode_ready,
    input  logic                 branch_eq_i,
    input  logic                 branch_ne_i,
    input  logic                 jump_i,
    input  logic                 zero_i,
    input  logic                 jr_i,
    input  logic [31:0]          jr_target_i,
    output logic [CNT_WIDTH-1:0] retired_cnt
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                 misalign_o
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {StFetch, StHold, StHalt} state_e;
`else
    typedef enum logic [1:0] {StFetch, StHold} state_e;
`endif

    state_e                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                  misalign_q, misalign_d;
`endif

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic [31:0] next_pc;

    // Next-PC datapath. It is evaluated every cycle, but it only matters in HOLD,
    // where instr_q and pc_q are stable.
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        branch_target = pc_plus4 + branch_offset;
        // If the decoder asserts both branch flags, the branch is taken when either
        // condition holds.
        branch_taken  = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);

        if (jr_i) begin
            next_pc = jr_target_i;
        end else if (jump_i) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

    // Next-state logic for the FSM and the architectural registers.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif

        case (state_q)
            StFetch: begin
                // An ack in the same cycle that req rises is accepted, so a fetch
                // can take zero wait states.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                // An ack that arrives in HOLD is ignored; only decode_ready matters.
                if (decode_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (next_pc[1:0] != 2'b00) begin
                        // Keep the raw target so software can see where the trap came from.
                        pc_d       = next_pc;
                        misalign_d = 1'b1;
                        state_d    = StHalt;
                    end else begin
                        pc_d    = next_pc;
                        state_d = StFetch;
                    end
`else
                    pc_d    = next_pc & ~32'd3;
                    state_d = StFetch;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            StHalt: begin
                // Only reset leaves HALT.
                state_d = StHalt;
            end
`endif
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Gate the request with reset so that it drops as soon as reset rises. Without the
    // gate, req would stay high while the register sits in its FETCH reset value.
    assign imem_req    = (state_q == StFetch) & ~reset;
    assign imem_addr   = pc_q;
    assign instr_o     = instr_q;
    assign instr_valid = valid_q;
    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_plus4;
    assign retired_cnt = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o  = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
//
// The bench runs a directed walk through the reset, handshake and next-PC cases.
// It then runs a long randomized phase. Every cycle it compares the DUT against a
// transaction-level model of the fetch stage.

module tb_fetch_unit;

    localparam logic [31:0] ResetPc = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_o;
    logic        instr_valid;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        decode_ready;
    logic        branch_eq_i;
    logic        branch_ne_i;
    logic        jump_i;
    logic        zero_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic [31:0] retired_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (ResetPc),
        .CNT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_o      (instr_o),
        .instr_valid  (instr_valid),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .decode_ready (decode_ready),
        .branch_eq_i  (branch_eq_i),
        .branch_ne_i  (branch_ne_i),
        .jump_i       (jump_i),
        .zero_i       (zero_i),
        .jr_i         (jr_i),
        .jr_target_i  (jr_target_i),
        .retired_cnt  (retired_cnt)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state. The model tracks whether an instruction is held; it does
    // not track an FSM encoding.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_held;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compute the architectural target directly from the instruction fields.
    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [31:0] instr,
                                                 input bit beq, input bit bne, input bit j,
                                                 input bit z, input bit jr,
                                                 input logic [31:0] jrt);
        logic [31:0] link;
        int          offs;
        link = pc + 32'd4;
        if (jr) return jrt;
        if (j) return (link & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
        if ((beq && z) || (bne && !z)) begin
            offs = int'($signed(instr[15:0])) * 4;
            return link + 32'(offs);
        end
        return link;
    endfunction

    task automatic model_reset();
        m_pc    = ResetPc;
        m_instr = 32'd0;
        m_held  = 1'b0;
        m_cnt   = 32'd0;
    endtask

    task automatic model_step();
        if (!m_held) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_held  = 1'b1;
            end
        end else if (decode_ready) begin
            m_pc   = model_target(m_pc, m_instr, branch_eq_i, branch_ne_i, jump_i, zero_i,
                                  jr_i, jr_target_i) & ~32'd3;
            m_held = 1'b0;
            m_cnt  = m_cnt + 32'd1;
        end
    endtask

    task automatic compare_model();
        check("m_req",   32'(imem_req),    32'(!m_held));
        check("m_addr",  imem_addr,        m_pc);
        check("m_pc",    pc_o,             m_pc);
        check("m_pc4",   pc_plus4_o,       m_pc + 32'd4);
        check("m_valid", 32'(instr_valid), 32'(m_held));
        check("m_instr", instr_o,          m_instr);
        check("m_cnt",   retired_cnt,      m_cnt);
    endtask

    task automatic clear_in();
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;
        decode_ready = 1'b0;
        branch_eq_i  = 1'b0;
        branch_ne_i  = 1'b0;
        jump_i       = 1'b0;
        zero_i       = 1'b0;
        jr_i         = 1'b0;
        jr_target_i  = 32'd0;
    endtask

    // Advance one cycle with the current inputs, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic fetch_now(input logic [31:0] word);
        clear_in();
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        clear_in();
    endtask

    task automatic retire_now();
        decode_ready = 1'b1;
        tick();
        clear_in();
    endtask

    task automatic goto_pc(input logic [31:0] target);
        fetch_now(32'd0);
        jr_i        = 1'b1;
        jr_target_i = target;
        retire_now();
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_req",  32'(imem_req), 32'd1);
        check("rel_addr", imem_addr,     32'h0040_0000);
        check("rel_cnt",  retired_cnt,   32'd0);

        // Ack delayed by 3 cycles: the address must not move while waiting.
        repeat (3) begin
            tick();
            check("wait_addr", imem_addr, 32'h0040_0000);
        end
        fetch_now(32'h2008_0005);
        check("fetch_valid", 32'(instr_valid), 32'd1);
        check("fetch_instr", instr_o,          32'h2008_0005);
        // Hold for 4 cycles. The stray acks in HOLD must be ignored.
        repeat (4) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            tick();
            check("hold_instr", instr_o,       32'h2008_0005);
            check("hold_req",   32'(imem_req), 32'd0);
        end
        clear_in();
        retire_now();
        check("seq_addr", imem_addr,   32'h0040_0004);
        check("seq_cnt",  retired_cnt, 32'd1);

        // BEQ taken.
        fetch_now(32'd0);
        retire_now();
        fetch_now(32'h1109_0003);
        branch_eq_i = 1'b1;
        zero_i      = 1'b1;
        retire_now();
        check("beq_taken", imem_addr, 32'h0040_0018);
        // BEQ not taken.
        goto_pc(32'h0040_0008);
        fetch_now(32'h1109_0003);
        branch_eq_i = 1'b1;
        retire_now();
        check("beq_not", imem_addr, 32'h0040_000C);
        // BNE with a negative offset.
        goto_pc(32'h0040_0010);
        fetch_now(32'h1509_FFFC);
        branch_ne_i = 1'b1;
        retire_now();
        check("bne_neg", imem_addr, 32'h0040_0004);
        // With both branch flags set, the branch is taken either way.
        fetch_now(32'h1109_0003);
        branch_eq_i = 1'b1;
        branch_ne_i = 1'b1;
        retire_now();
        check("both_br", imem_addr, 32'h0040_0014);
        // J, then JR taking priority over J.
        fetch_now(32'h0810_0004);
        jump_i = 1'b1;
        retire_now();
        check("j_addr", imem_addr, 32'h0040_0010);
        fetch_now(32'h0810_0004);
        jump_i      = 1'b1;
        jr_i        = 1'b1;
        jr_target_i = 32'h0040_0020;
        retire_now();
        check("jr_wins", imem_addr, 32'h0040_0020);

        // PC wraps from the top of the address space.
        goto_pc(32'hFFFF_FFFC);
        fetch_now(32'd0);
        check("wrap_pc4", pc_plus4_o, 32'd0);
        retire_now();
        check("wrap_addr", imem_addr, 32'd0);

        // Misaligned JR target.
        fetch_now(32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        jr_i         = 1'b1;
        jr_target_i  = 32'h0040_0006;
        decode_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_in();
        imem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("halt_mis", 32'(misalign_o),  32'd1);
            check("halt_req", 32'(imem_req),    32'd0);
            check("halt_val", 32'(instr_valid), 32'd0);
            check("halt_pc",  pc_o,             32'h0040_0006);
        end
        do_reset();
        check("mis_clr", 32'(misalign_o), 32'd0);
`else
        jr_i        = 1'b1;
        jr_target_i = 32'h0040_0006;
        retire_now();
        check("mis_force", imem_addr, 32'h0040_0004);
`endif

        // Reset during a FETCH wait. A late ack seen under reset is ignored.
        tick();
        reset = 1'b1;
        #1;
        check("rstf_req", 32'(imem_req),    32'd0);
        check("rstf_pc",  pc_o,             ResetPc);
        check("rstf_val", 32'(instr_valid), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("rstf_ack", 32'(instr_valid), 32'd0);
        clear_in();
        model_reset();
        reset = 1'b0;
        #1;
        check("rstf_rel", 32'(imem_req), 32'd1);
        check("rstf_ins", instr_o,       32'd0);

        // Reset during HOLD.
        fetch_now(32'hABCD_0001);
        retire_now();
        fetch_now(32'hABCD_0002);
        reset = 1'b1;
        #1;
        check("rsth_req", 32'(imem_req),    32'd0);
        check("rsth_pc",  pc_o,             ResetPc);
        check("rsth_val", 32'(instr_valid), 32'd0);
        check("rsth_cnt", retired_cnt,      32'd0);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            imem_ack     = ($urandom_range(0, 1) == 1);
            imem_rdata   = $urandom();
            decode_ready = ($urandom_range(0, 2) != 0);
            branch_eq_i  = ($urandom_range(0, 3) == 0);
            branch_ne_i  = ($urandom_range(0, 3) == 0);
            jump_i       = ($urandom_range(0, 5) == 0);
            zero_i       = ($urandom_range(0, 1) == 1);
            jr_i         = ($urandom_range(0, 7) == 0);
            jr_target_i  = $urandom();
`ifdef FETCH_MISALIGN_TRAP_EN
            jr_target_i  = jr_target_i & ~32'd3;
`endif
            tick();
        end
        clear_in();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
